// File: rtl/sram_ctrl_param.sv
// Parametrised async SRAM controller with a request/ready host handshake and
// programmable setup/access/hold wait states; every SRAM-side output is registered.
module sram_ctrl_param #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned ACCESS_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              done,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [DATA_W-1:0] sram_dq_in,
  output logic              nCS,
  output logic              nOE,
  output logic              nWE
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

  // Each phase counter is loaded with its length minus one and exits at zero.
  localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYC - 1);
  localparam logic [7:0] ACCESS_LD = 8'(ACCESS_CYC - 1);
  localparam logic [7:0] HOLD_LD   = 8'(HOLD_CYC - 1);
  localparam bit         HAS_HOLD  = (HOLD_CYC != 0);

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   dq_out_q, dq_out_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                ncs_q, ncs_d;
  logic                noe_q, noe_d;
  logic                nwe_q, nwe_d;
  logic                oe_q, oe_d;
  logic                done_q, done_d;
  logic                rvalid_q, rvalid_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      dq_out_q <= '0;
      rdata_q  <= '0;
      ncs_q    <= 1'b1;
      noe_q    <= 1'b1;
      nwe_q    <= 1'b1;
      oe_q     <= 1'b0;
      done_q   <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      dq_out_q <= dq_out_d;
      rdata_q  <= rdata_d;
      ncs_q    <= ncs_d;
      noe_q    <= noe_d;
      nwe_q    <= nwe_d;
      oe_q     <= oe_d;
      done_q   <= done_d;
      rvalid_q <= rvalid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    dq_out_d = dq_out_q;
    rdata_d  = rdata_q;
    ncs_d    = ncs_q;
    noe_d    = noe_q;
    nwe_d    = nwe_q;
    oe_d     = oe_q;
    done_d   = 1'b0;
    rvalid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          state_d  = SETUP;
          cnt_d    = SETUP_LD;
          we_d     = we;
          addr_d   = addr;
          dq_out_d = wdata;
          ncs_d    = 1'b0;
        end
      end
      SETUP: begin
        if (cnt_q == 8'd0) begin
          state_d = ACCESS;
          cnt_d   = ACCESS_LD;
          if (we_q) begin
            nwe_d = 1'b0;
            oe_d  = 1'b1;
          end else begin
            noe_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ACCESS: begin
        if (cnt_q == 8'd0) begin
          noe_d    = 1'b1;
          nwe_d    = 1'b1;
          done_d   = 1'b1;
          rvalid_d = ~we_q;
          if (!we_q) rdata_d = sram_dq_in;
          // Writes keep driving the bus through HOLD; with no HOLD the bus is released here.
          if (HAS_HOLD) begin
            state_d = HOLD;
            cnt_d   = HOLD_LD;
          end else begin
            state_d = IDLE;
            ncs_d   = 1'b1;
            oe_d    = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      HOLD: begin
        if (cnt_q == 8'd0) begin
          state_d = IDLE;
          ncs_d   = 1'b1;
          oe_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready       = (state_q == IDLE);
  assign done        = done_q;
  assign rvalid      = rvalid_q;
  assign rdata       = rdata_q;
  assign sram_addr   = addr_q;
  assign sram_dq_out = dq_out_q;
  assign sram_dq_oe  = oe_q;
  assign nCS         = ncs_q;
  assign nOE         = noe_q;
  assign nWE         = nwe_q;

endmodule

// File: tb/tb_sram_ctrl_param.sv
// Directed bench for sram_ctrl_param: default timing (with an SRAM model) and a
// SETUP=2/ACCESS=3/HOLD=0 instance.
module tb_sram_ctrl_param;
  logic clk, rst;
  int checks = 0;
  int errors = 0;
  int n_acc = 0;
  int n_done = 0;

  logic        req_a, we_a, ready_a, done_a, rvalid_a, dq_oe_a, ncs_a, noe_a, nwe_a;
  logic [15:0] addr_a, sram_addr_a;
  logic [7:0]  wdata_a, rdata_a, dq_out_a, dq_in_a;
  logic        req_b, we_b, ready_b, done_b, rvalid_b, dq_oe_b, ncs_b, noe_b, nwe_b;
  logic [15:0] addr_b, sram_addr_b;
  logic [7:0]  wdata_b, rdata_b, dq_out_b, dq_in_b;

  logic [7:0] mem [0:65535];
  logic [7:0] model [0:7];

  sram_ctrl_param dut_a (
    .clk(clk), .rst(rst), .req(req_a), .we(we_a), .addr(addr_a), .wdata(wdata_a),
    .ready(ready_a), .done(done_a), .rvalid(rvalid_a), .rdata(rdata_a),
    .sram_addr(sram_addr_a), .sram_dq_out(dq_out_a), .sram_dq_oe(dq_oe_a),
    .sram_dq_in(dq_in_a), .nCS(ncs_a), .nOE(noe_a), .nWE(nwe_a));

  sram_ctrl_param #(.SETUP_CYC(2), .ACCESS_CYC(3), .HOLD_CYC(0)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .we(we_b), .addr(addr_b), .wdata(wdata_b),
    .ready(ready_b), .done(done_b), .rvalid(rvalid_b), .rdata(rdata_b),
    .sram_addr(sram_addr_b), .sram_dq_out(dq_out_b), .sram_dq_oe(dq_oe_b),
    .sram_dq_in(dq_in_b), .nCS(ncs_b), .nOE(noe_b), .nWE(nwe_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Async SRAM model: drives data while nOE is low, stores on the rising edge of nWE.
  assign dq_in_a = noe_a ? 8'hEE : mem[sram_addr_a];
  always @(posedge nwe_a) if (!rst) mem[sram_addr_a] = dq_out_a;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    check("no_strobe_overlap_a", {31'd0, ~(~noe_a & ~nwe_a)}, 32'd1);
    check("no_oe_during_read_a", {31'd0, ~(dq_oe_a & ~noe_a)}, 32'd1);
    check("no_strobe_overlap_b", {31'd0, ~(~noe_b & ~nwe_b)}, 32'd1);
    if (done_a) n_done++;
    if (ready_a && req_a && !rst) n_acc++;
  end

  task automatic do_txn(input logic w, input logic [15:0] a, input logic [7:0] d,
                        input logic [7:0] exp_rd);
    int k;
    k = 0;
    while (!ready_a && k < 20) begin tick(); k++; end
    check("txn_ready", {31'd0, ready_a}, 32'd1);
    req_a = 1'b1; we_a = w; addr_a = a; wdata_a = d;
    tick();
    req_a = 1'b0;
    k = 0;
    while (!done_a && k < 20) begin tick(); k++; end
    check("txn_done", {31'd0, done_a}, 32'd1);
    check("txn_rvalid", {31'd0, rvalid_a}, {31'd0, ~w});
    if (!w) check("txn_rdata", {24'd0, rdata_a}, {24'd0, exp_rd});
  endtask

  initial begin
    logic [4:0] e_ncs, e_noe, e_nwe, e_oe, e_done, e_rdy;
    logic [5:0] f_ncs, f_noe, f_done;
    logic [15:0] ra;
    logic [7:0]  rd;
    logic        rw;

    rst = 1'b1;
    req_a = 0; we_a = 0; addr_a = '0; wdata_a = '0;
    req_b = 0; we_b = 0; addr_b = '0; wdata_b = '0; dq_in_b = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h1234] = 8'hA5;
    tick(); tick();
    check("rst_ncs", {31'd0, ncs_a}, 32'd1);
    check("rst_noe", {31'd0, noe_a}, 32'd1);
    check("rst_nwe", {31'd0, nwe_a}, 32'd1);
    check("rst_oe", {31'd0, dq_oe_a}, 32'd0);
    check("rst_addr", {16'd0, sram_addr_a}, 32'd0);
    check("rst_dqout", {24'd0, dq_out_a}, 32'd0);
    check("rst_rdata", {24'd0, rdata_a}, 32'd0);
    check("rst_done", {30'd0, done_a, rvalid_a}, 32'd0);
    check("rst_ready", {31'd0, ready_a}, 32'd1);
    rst = 1'b0;
    tick();

    // Read 0x1234 with SRAM returning 0xA5; bit k-1 = cycle k.
    e_ncs = 5'b10000; e_noe = 5'b11001; e_done = 5'b01000; e_rdy = 5'b10000;
    req_a = 1'b1; we_a = 1'b0; addr_a = 16'h1234;
    tick();
    req_a = 1'b0;
    check("rd_addr", {16'd0, sram_addr_a}, 32'h1234);
    for (int c = 1; c <= 5; c++) begin
      check($sformatf("rd_ncs_c%0d", c), {31'd0, ncs_a}, {31'd0, e_ncs[c-1]});
      check($sformatf("rd_noe_c%0d", c), {31'd0, noe_a}, {31'd0, e_noe[c-1]});
      check($sformatf("rd_nwe_c%0d", c), {31'd0, nwe_a}, 32'd1);
      check($sformatf("rd_done_c%0d", c), {31'd0, done_a}, {31'd0, e_done[c-1]});
      check($sformatf("rd_rvalid_c%0d", c), {31'd0, rvalid_a}, {31'd0, e_done[c-1]});
      check($sformatf("rd_ready_c%0d", c), {31'd0, ready_a}, {31'd0, e_rdy[c-1]});
      if (c == 4) check("rd_rdata", {24'd0, rdata_a}, 32'hA5);
      if (c < 5) tick();
    end

    // Write 0x3C to 0x00FF.
    e_nwe = 5'b11001; e_oe = 5'b01110;
    req_a = 1'b1; we_a = 1'b1; addr_a = 16'h00FF; wdata_a = 8'h3C;
    tick();
    req_a = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      check($sformatf("wr_nwe_c%0d", c), {31'd0, nwe_a}, {31'd0, e_nwe[c-1]});
      check($sformatf("wr_noe_c%0d", c), {31'd0, noe_a}, 32'd1);
      check($sformatf("wr_oe_c%0d", c), {31'd0, dq_oe_a}, {31'd0, e_oe[c-1]});
      check($sformatf("wr_ncs_c%0d", c), {31'd0, ncs_a}, {31'd0, e_ncs[c-1]});
      check($sformatf("wr_done_c%0d", c), {31'd0, done_a}, {31'd0, e_done[c-1]});
      check($sformatf("wr_rvalid_c%0d", c), {31'd0, rvalid_a}, 32'd0);
      if (e_oe[c-1]) check($sformatf("wr_dq_c%0d", c), {24'd0, dq_out_a}, 32'h3C);
      if (c < 5) tick();
    end
    check("wr_mem", {24'd0, mem[16'h00FF]}, 32'h3C);

    // Back-to-back with req held: write 0x11 to 0x10, then read 0x10.
    req_a = 1'b1; we_a = 1'b1; addr_a = 16'h0010; wdata_a = 8'h11;
    tick();
    we_a = 1'b0; wdata_a = 8'h99;
    for (int c = 1; c <= 5; c++) begin
      check($sformatf("b2b_w_ready_c%0d", c), {31'd0, ready_a}, {31'd0, e_rdy[c-1]});
      check($sformatf("b2b_w_nwe_c%0d", c), {31'd0, nwe_a}, {31'd0, e_nwe[c-1]});
      check($sformatf("b2b_w_noe_c%0d", c), {31'd0, noe_a}, 32'd1);
      if (c == 3) check("b2b_w_dq", {24'd0, dq_out_a}, 32'h11);
      if (c < 5) tick();
    end
    tick();
    req_a = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      check($sformatf("b2b_r_ready_c%0d", c), {31'd0, ready_a}, {31'd0, e_rdy[c-1]});
      check($sformatf("b2b_r_ncs_c%0d", c), {31'd0, ncs_a}, {31'd0, e_ncs[c-1]});
      check($sformatf("b2b_r_noe_c%0d", c), {31'd0, noe_a}, {31'd0, e_noe[c-1]});
      check($sformatf("b2b_r_rvalid_c%0d", c), {31'd0, rvalid_a}, {31'd0, e_done[c-1]});
      if (c == 4) check("b2b_r_rdata", {24'd0, rdata_a}, 32'h11);
      if (c < 5) tick();
    end

    // SETUP=2, ACCESS=3, HOLD=0 read; second req held to confirm accept at the done edge.
    f_ncs = 6'b100000; f_noe = 6'b100011; f_done = 6'b100000;
    dq_in_b = 8'h5A;
    req_b = 1'b1; we_b = 1'b0; addr_b = 16'h0BEE;
    tick();
    addr_b = 16'h0C00;
    for (int c = 1; c <= 6; c++) begin
      check($sformatf("h0_ncs_c%0d", c), {31'd0, ncs_b}, {31'd0, f_ncs[c-1]});
      check($sformatf("h0_noe_c%0d", c), {31'd0, noe_b}, {31'd0, f_noe[c-1]});
      check($sformatf("h0_done_c%0d", c), {31'd0, done_b}, {31'd0, f_done[c-1]});
      check($sformatf("h0_rvalid_c%0d", c), {31'd0, rvalid_b}, {31'd0, f_done[c-1]});
      check($sformatf("h0_ready_c%0d", c), {31'd0, ready_b}, {31'd0, f_done[c-1]});
      if (c == 6) check("h0_rdata", {24'd0, rdata_b}, 32'h5A);
      if (c < 6) tick();
    end
    tick();
    req_b = 1'b0;
    check("h0_reaccept_ncs", {31'd0, ncs_b}, 32'd0);
    check("h0_reaccept_ready", {31'd0, ready_b}, 32'd0);
    check("h0_reaccept_addr", {16'd0, sram_addr_b}, 32'h0C00);
    repeat (6) tick();

    // Asynchronous reset in cycle 2 of a write to 0x0042.
    req_a = 1'b1; we_a = 1'b1; addr_a = 16'h0042; wdata_a = 8'h77;
    tick();
    req_a = 1'b0;
    tick();
    check("rstmid_pre_nwe", {31'd0, nwe_a}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("rstmid_nwe", {31'd0, nwe_a}, 32'd1);
    check("rstmid_ncs", {31'd0, ncs_a}, 32'd1);
    check("rstmid_oe", {31'd0, dq_oe_a}, 32'd0);
    check("rstmid_rdata", {24'd0, rdata_a}, 32'd0);
    check("rstmid_ready", {31'd0, ready_a}, 32'd1);
    tick(); tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("rstmid_no_done", {31'd0, done_a}, 32'd0);
      check("rstmid_idle", {31'd0, ready_a}, 32'd1);
    end
    do_txn(1'b0, 16'h1234, 8'h00, 8'hA5);

    // Random traffic over 8 addresses against the model.
    tick();
    n_acc = 0; n_done = 0;
    for (int i = 0; i < 8; i++) begin
      rd = 8'($urandom_range(0, 255));
      model[i] = rd;
      do_txn(1'b1, 16'(i), rd, 8'h00);
    end
    for (int i = 0; i < 1000; i++) begin
      rw = 1'($urandom_range(0, 1));
      ra = 16'($urandom_range(0, 7));
      rd = 8'($urandom_range(0, 255));
      do_txn(rw, ra, rd, model[ra[2:0]]);
      if (rw) model[ra[2:0]] = rd;
    end
    tick(); tick();
    check("done_eq_accept", n_done, n_acc);
    check("accept_count", n_acc, 32'd1008);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
